cla2_serial_seq: RTL and testbench

Digit-serial add/subtract sequencer built around one 2-bit carry-lookahead slice. It has the same G/P/C1/Cout structure as the team's 2-bit CLA.
- Captures WIDTH-bit operands and feeds them through the slice 2 bits per cycle, LSB digit first, with a registered carry between digits.
- Publishes the full sum and carry-out with a one-cycle done pulse.
- Sits between the tile's I/O wrapper and the slice, giving wide arithmetic for small area.

---
 rtl/cla2_serial_seq.sv | 138 +++++++++++++
 tb/tb_cla2_serial_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla2_serial_seq.sv
// Digit-serial add/subtract sequencer around one 2-bit carry-lookahead slice.
// Define CLA2_SUB_EN to add the `sub` input and the `ovf` output.
module cla2_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA2_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA2_SUB_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / 2;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [SW-1:0]    r_step;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic [1:0]       w_g;
    logic [1:0]       w_p;
    logic             w_c1;
    logic             w_co;
    logic [1:0]       w_s;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_b_in;
    logic             w_cin_in;

`ifdef CLA2_SUB_EN
    logic             r_ovf;
    // Subtraction is a + ~b + 1; cin is ignored in that mode.
    assign w_b_in   = sub ? ~b : b;
    assign w_cin_in = sub ? 1'b1 : cin;
    assign ovf      = r_ovf;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_step == LAST_STEP);

    // The 2-bit lookahead slice.
    assign w_g  = r_a_sh[1:0] & r_b_sh[1:0];
    assign w_p  = r_a_sh[1:0] ^ r_b_sh[1:0];
    assign w_c1 = w_g[0] | (w_p[0] & r_carry);
    assign w_co = w_g[1] | (w_p[1] & w_c1);
    assign w_s  = {w_p[1] ^ w_c1, w_p[0] ^ r_carry};

    generate
        if (WIDTH > 2) begin : g_wide
            assign w_res_next = {w_s, r_res_sh[WIDTH-1:2]};
        end else begin : g_narrow
            assign w_res_next = w_s;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_step == LAST_STEP) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_step   <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
`ifdef CLA2_SUB_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_in;
            r_carry <= w_cin_in;
            r_step  <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh   <= r_a_sh >> 2;
            r_b_sh   <= r_b_sh >> 2;
            r_res_sh <= w_res_next;
            r_carry  <= w_co;
            r_step   <= r_step + 1'b1;
            // Outputs move only on the final digit so partial sums never show.
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_co;
`ifdef CLA2_SUB_EN
                r_ovf  <= w_c1 ^ w_co;
`endif
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_cla2_serial_seq.sv
// Self-checking bench for cla2_serial_seq (WIDTH=8): arithmetic reference model
// compared every cycle, plus directed literal checks.
module tb_cla2_serial_seq;

    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf_obs;

    int n_checks = 0;
    int n_pass   = 0;

    cla2_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef CLA2_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef CLA2_SUB_EN
        ,
        .ovf   (ovf_obs)
`endif
    );

`ifndef CLA2_SUB_EN
    assign ovf_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
    endtask

    // ---------------- reference model: plain arithmetic + countdown ----------------
    int               m_rem, m_rem_n;
    logic [WIDTH:0]   m_pend, m_pend_n;
    logic             m_povf, m_povf_n;
    logic [WIDTH-1:0] m_sum, m_sum_n;
    logic             m_cout, m_cout_n, m_ovf, m_ovf_n, m_done, m_done_n;
    logic             m_sub;
    logic [WIDTH-1:0] m_bb;
    logic             m_cc;
    logic [WIDTH:0]   m_total;

`ifdef CLA2_SUB_EN
    assign m_sub = sub;
`else
    assign m_sub = 1'b0;
`endif

    always_comb begin
        m_rem_n  = m_rem;
        m_pend_n = m_pend;
        m_povf_n = m_povf;
        m_sum_n  = m_sum;
        m_cout_n = m_cout;
        m_ovf_n  = m_ovf;
        m_done_n = 1'b0;
        m_bb     = m_sub ? ~b : b;
        m_cc     = m_sub ? 1'b1 : cin;
        m_total  = {1'b0, a} + {1'b0, m_bb} + {{WIDTH{1'b0}}, m_cc};
        if (m_rem != 0) begin
            m_rem_n = m_rem - 1;
            if (m_rem == 1) begin
                m_sum_n  = m_pend[WIDTH-1:0];
                m_cout_n = m_pend[WIDTH];
                m_ovf_n  = m_povf;
                m_done_n = 1'b1;
            end
        end else if (start) begin
            m_rem_n  = N;
            m_pend_n = m_total;
            m_povf_n = (a[WIDTH-1] == m_bb[WIDTH-1]) && (m_total[WIDTH-1] != a[WIDTH-1]);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_pend <= '0;
            m_povf <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_rem  <= m_rem_n;
            m_pend <= m_pend_n;
            m_povf <= m_povf_n;
            m_sum  <= m_sum_n;
            m_cout <= m_cout_n;
            m_ovf  <= m_ovf_n;
            m_done <= m_done_n;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("busy", {31'b0, busy}, {31'b0, m_rem != 0});
        chk("done", {31'b0, done}, {31'b0, m_done});
        chk("sum",  {24'b0, sum},  {24'b0, m_sum});
        chk("cout", {31'b0, cout}, {31'b0, m_cout});
`ifdef CLA2_SUB_EN
        chk("ovf",  {31'b0, ovf_obs}, {31'b0, m_ovf});
`endif
    end

    // One full operation with literal expectations on busy, done and result.
    task automatic do_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tc, input logic ts, input logic [7:0] esum,
                         input logic ecout, input logic eovf);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; cin = tc; sub = ts;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        chk({nm, "_busy0"}, {31'b0, busy}, 32'd1);
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        chk({nm, "_done"}, {31'b0, done}, 32'd1);
        chk({nm, "_sum"},  {24'b0, sum},  {24'b0, esum});
        chk({nm, "_cout"}, {31'b0, cout}, {31'b0, ecout});
`ifdef CLA2_SUB_EN
        chk({nm, "_ovf"},  {31'b0, ovf_obs}, {31'b0, eovf});
`else
        if (eovf === 1'bx) $display("unused ovf expectation");
`endif
        $display("op %s: a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d", nm, ta, tb_v, tc, ts, sum, cout);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum",  {24'b0, sum},  32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1, 2: basic add and carry-out cases
        do_op("t1",  8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        do_op("t2a", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("t2b", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // 3: start during RUN is ignored
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t3_done", {31'b0, done}, 32'd1);
        chk("t3_sum",  {24'b0, sum},  32'h46);
        chk("t3_cout", {31'b0, cout}, 32'd0);
        @(negedge clk);
        chk("t3_nodone", {31'b0, done}, 32'd0);
        $display("op t3: 12+34 with ignored start -> sum=%02h cout=%0d", sum, cout);

        // 4: start held high, back-to-back operations
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        @(negedge clk); a = 8'h80; b = 8'h80;
        repeat (N) @(negedge clk);
        chk("t4a_done", {31'b0, done}, 32'd1);
        chk("t4a_sum",  {24'b0, sum},  32'h03);
        chk("t4a_cout", {31'b0, cout}, 32'd0);
        repeat (N + 1) @(negedge clk);
        chk("t4b_done", {31'b0, done}, 32'd1);
        chk("t4b_sum",  {24'b0, sum},  32'h00);
        chk("t4b_cout", {31'b0, cout}, 32'd1);
        start = 1'b0;
        $display("op t4: back-to-back done, last sum=%02h cout=%0d", sum, cout);
        @(negedge clk);

        // 5: reset mid-RUN aborts
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_done", {31'b0, done}, 32'd0);
        chk("t5_sum",  {24'b0, sum},  32'd0);
        chk("t5_cout", {31'b0, cout}, 32'd0);
        #2 rst_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        chk("t5_nodone", {31'b0, done}, 32'd0);
        do_op("t5", 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

`ifdef CLA2_SUB_EN
        // 6: subtract mode and signed overflow
        do_op("t6a", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        do_op("t6b", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        do_op("t6c", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
`endif

        // Randomized traffic, including starts during RUN and a reset.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            a     = 8'($urandom);
            b     = 8'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
            if (i == 600) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            if (done) $display("rand op %0d: sum=%02h cout=%0d", i, sum, cout);
        end
        start = 1'b0;
        repeat (N + 2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
